spi_fsm_controller: RTL and testbench

//  Transaction sequencer for the SPI memory datapath (input conditioners -> shift register -> address latch/data memory).

---
 rtl/spi_fsm_controller.sv | 216 +++++++++++++++++++++
 tb/tb_spi_fsm_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fsm_controller.sv
// -----------------------------------------------------------------------------
// spi_fsm_controller
// Transaction sequencer for the SPI memory datapath. It watches the conditioned
// chip select and SCLK rising-edge pulses, counts address/R/W/data bits, and
// emits one-cycle strobes for the address latch, the shift-register parallel
// load and the data memory, plus the MISO tri-state enable.
//
// Frame: cs low, ADDR_BITS address bits, 1 R/W bit (1 = read), then DATA_BITS
// data bits, MSB first.
//
// Optional feature: define SPI_TIMEOUT_EN to abort a frame that stalls for
// TIMEOUT_CYCLES clk cycles in a bit-counting state.
//
// Ports:
//   clk           system clock, all state on posedge
//   reset         asynchronous, active-high; forces IDLE
//   cs            conditioned chip select, active low
//   sclk_posedge  one-clk pulse per conditioned SCLK rising edge
//   sr_lsb        shift-register bit 0 (R/W bit after the address phase)
//   addr_we       address-latch write enable (1 cycle)
//   sr_we         shift-register parallel-load enable (1 cycle)
//   dm_we         data-memory write enable (1 cycle)
//   miso_bufe     MISO tri-state buffer enable
//   busy          high in every state except IDLE
//   state         current state encoding (debug)
//   timeout       one-clk abort pulse (constant 0 without SPI_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module spi_fsm_controller #(
    parameter int unsigned ADDR_BITS      = 7,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk_posedge,
    input  logic       sr_lsb,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_bufe,
    output logic       busy,
    output logic [2:0] state,
    output logic       timeout
);

    localparam int unsigned ADDR_CNT = ADDR_BITS + 1;
    localparam int unsigned CNT_MAX  = (ADDR_CNT > DATA_BITS) ? ADDR_CNT : DATA_BITS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET         = 3'd1,
        S_GOT         = 3'd2,
        S_READ_LOAD   = 3'd3,
        S_READ_SEND   = 3'd4,
        S_WRITE_RECV  = 3'd5,
        S_WRITE_STORE = 3'd6,
        S_DONE        = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             armed_q;
    logic             timeout_c;
    logic             idle_expired_c;

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign state     = state_q;

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q;

    // Counts clk cycles without SCLK activity in the current state; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if (sclk_posedge || (state_d != state_q)) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
        end
    end

    // True on the edge that completes TIMEOUT_CYCLES idle cycles.
    assign idle_expired_c = !sclk_posedge && (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: parameter kept for interface compatibility only.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign idle_expired_c     = 1'b0;
`endif

    // A new frame needs cs seen high after reset, so a reset mid-frame
    // with cs still low does not restart on a partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (cs) begin
            armed_q <= 1'b1;
        end
    end

    // State and bit-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cs high always wins over a simultaneous SCLK pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cs && armed_q) begin
                    state_d = S_GET;
                    cnt_d   = '0;
                end
            end
            S_GET: begin
                if (cs) begin
                    state_d = S_IDLE;
                end else if (sclk_posedge) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(ADDR_CNT)) begin
                        state_d = S_GOT;
                    end
                end else if (idle_expired_c) begin
                    state_d   = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_GOT: begin
                cnt_d = '0;
                if (cs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = sr_lsb ? S_READ_LOAD : S_WRITE_RECV;
                end
            end
            S_READ_LOAD: begin
                state_d = cs ? S_IDLE : S_READ_SEND;
            end
            S_READ_SEND: begin
                if (cs) begin
                    state_d = S_IDLE;
                end else if (sclk_posedge) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(DATA_BITS)) begin
                        state_d = S_DONE;
                    end
                end else if (idle_expired_c) begin
                    state_d   = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_WRITE_RECV: begin
                if (cs) begin
                    state_d = S_IDLE;
                end else if (sclk_posedge) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(DATA_BITS)) begin
                        state_d = S_WRITE_STORE;
                    end
                end else if (idle_expired_c) begin
                    state_d   = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_WRITE_STORE: begin
                state_d = cs ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs registered from the next-state decode so they line up with
    // the state register while staying glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
            dm_we     <= 1'b0;
            miso_bufe <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            addr_we   <= (state_d == S_GOT);
            sr_we     <= (state_d == S_READ_LOAD);
            dm_we     <= (state_d == S_WRITE_STORE);
            miso_bufe <= (state_d == S_READ_SEND);
            busy      <= (state_d != S_IDLE);
            timeout   <= timeout_c;
        end
    end

endmodule

// File: tb/tb_spi_fsm_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm_controller
// Directed bench for spi_fsm_controller. Strobe events (addr_we, sr_we, dm_we,
// timeout) are predicted into a queue as stimulus is driven and popped when
// the DUT raises them; state/enable levels are checked directly.
// -----------------------------------------------------------------------------
module tb_spi_fsm_controller;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       sclk_posedge;
    logic       sr_lsb;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_bufe;
    logic       busy;
    logic [2:0] state;
    logic       timeout;

    int         checks;
    int         failures;
    logic [3:0] exp_q[$];
    logic       saw_timeout;

    // Strobe codes: {addr_we, sr_we, dm_we, timeout}
    localparam logic [3:0] EV_ADDR = 4'b1000;
    localparam logic [3:0] EV_SR   = 4'b0100;
    localparam logic [3:0] EV_DM   = 4'b0010;
    localparam logic [3:0] EV_TO   = 4'b0001;

    spi_fsm_controller dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .sclk_posedge (sclk_posedge),
        .sr_lsb       (sr_lsb),
        .addr_we      (addr_we),
        .sr_we        (sr_we),
        .dm_we        (dm_we),
        .miso_bufe    (miso_bufe),
        .busy         (busy),
        .state        (state),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, score strobes.
    task automatic tick();
        logic [3:0] ev;
        logic [3:0] exp_ev;
        @(posedge clk);
        #1;
        ev = {addr_we, sr_we, dm_we, timeout};
        if (ev != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (ev === 4'b0000) else begin
                    failures++;
                    $error("FAIL unexpected_strobe observed=%b expected=%b", ev, 4'b0000);
                end
            end else begin
                exp_ev = exp_q.pop_front();
                checks++;
                assert (ev === exp_ev) else begin
                    failures++;
                    $error("FAIL strobe observed=%b expected=%b", ev, exp_ev);
                end
                if (ev[0]) saw_timeout = 1'b1;
            end
        end
    endtask

    // n SCLK pulses, each preceded by one quiet cycle; returns just after the last pulse edge.
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            sclk_posedge = 1'b1;
            tick();
            sclk_posedge = 1'b0;
        end
    endtask

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        saw_timeout  = 1'b0;
        reset        = 1'b1;
        cs           = 1'b1;
        sclk_posedge = 1'b0;
        sr_lsb       = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_state",     32'(state),     32'd0);
        check("rst_addr_we",   32'(addr_we),   32'd0);
        check("rst_sr_we",     32'(sr_we),     32'd0);
        check("rst_dm_we",     32'(dm_we),     32'd0);
        check("rst_miso_bufe", 32'(miso_bufe), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        reset = 1'b0;
        tick();
        check("idle_state", 32'(state), 32'd0);

        // Write frame: addr 1010101, R/W 0, 8 data bits
        cs = 1'b0;
        tick();
        check("wr_get_state", 32'(state), 32'd1);
        check("wr_get_busy",  32'(busy),  32'd1);
        sr_lsb = 1'b0;
        pulses(7);
        exp_q.push_back(EV_ADDR);
        pulses(1);
        check("wr_got_state", 32'(state), 32'd2);
        tick();
        check("wr_recv_state", 32'(state), 32'd5);
        pulses(7);
        check("wr_recv_hold", 32'(state), 32'd5);
        exp_q.push_back(EV_DM);
        pulses(1);
        check("wr_store_state", 32'(state), 32'd6);
        tick();
        check("wr_done_state", 32'(state), 32'd7);
        check("wr_done_busy",  32'(busy),  32'd1);
        pulses(2);
        check("wr_done_ignores_sclk", 32'(state), 32'd7);
        cs = 1'b1;
        tick();
        check("wr_end_state", 32'(state), 32'd0);
        check("wr_end_busy",  32'(busy),  32'd0);
        check("wr_drained", 32'(exp_q.size()), 32'd0);

        // Read frame: addr 0000011, R/W 1
        cs = 1'b0;
        tick();
        sr_lsb = 1'b1;
        pulses(7);
        exp_q.push_back(EV_ADDR);
        exp_q.push_back(EV_SR);
        pulses(1);
        check("rd_got_state", 32'(state), 32'd2);
        tick();
        check("rd_load_state", 32'(state), 32'd3);
        check("rd_load_miso",  32'(miso_bufe), 32'd0);
        tick();
        check("rd_send_state", 32'(state), 32'd4);
        check("rd_send_miso",  32'(miso_bufe), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pulses(1);
            if (i < 8) check("rd_miso_during", 32'(miso_bufe), 32'd1);
        end
        check("rd_done_state", 32'(state), 32'd7);
        check("rd_done_miso",  32'(miso_bufe), 32'd0);
        cs = 1'b1;
        tick();
        check("rd_drained", 32'(exp_q.size()), 32'd0);

        // Abort in GET after 3 pulses
        cs = 1'b0;
        tick();
        pulses(3);
        cs = 1'b1;
        tick();
        check("abort_state", 32'(state), 32'd0);
        repeat (3) tick();
        check("abort_busy", 32'(busy), 32'd0);

        // Collision: cs rises on the 8th pulse
        cs = 1'b0;
        sr_lsb = 1'b0;
        tick();
        pulses(7);
        tick();
        sclk_posedge = 1'b1;
        cs = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        check("coll_state", 32'(state), 32'd0);
        tick();
        check("coll_state_hold", 32'(state), 32'd0);
        cs = 1'b0;
        tick();
        pulses(7);
        exp_q.push_back(EV_ADDR);
        pulses(1);
        tick();
        check("coll_next_recv", 32'(state), 32'd5);
        pulses(7);
        exp_q.push_back(EV_DM);
        pulses(1);
        tick();
        check("coll_next_done", 32'(state), 32'd7);
        cs = 1'b1;
        tick();
        check("coll_drained", 32'(exp_q.size()), 32'd0);

        // Async reset in READ_SEND, between clock edges
        cs = 1'b0;
        tick();
        sr_lsb = 1'b1;
        pulses(7);
        exp_q.push_back(EV_ADDR);
        exp_q.push_back(EV_SR);
        pulses(1);
        tick();
        tick();
        check("ar_send_state", 32'(state), 32'd4);
        pulses(3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_miso", 32'(miso_bufe), 32'd0);
        check("ar_busy", 32'(busy),      32'd0);
        check("ar_state", 32'(state),    32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("ar_no_restart_cs_low", 32'(state), 32'd0);
        cs = 1'b1;
        tick();
        cs = 1'b0;
        tick();
        check("ar_new_frame", 32'(state), 32'd1);
        cs = 1'b1;
        tick();
        check("ar_drained", 32'(exp_q.size()), 32'd0);

        // Stall in GET after 2 pulses
        cs = 1'b0;
        tick();
        pulses(2);
`ifdef SPI_TIMEOUT_EN
        exp_q.push_back(EV_TO);
        saw_timeout = 1'b0;
        n = 0;
        while (!saw_timeout && n < 1100) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'd1024);
        check("to_state",   32'(state), 32'd7);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_done_hold", 32'(state), 32'd7);
`else
        n = 0;
        repeat (1100) begin
            tick();
            n++;
        end
        check("nto_timeout", 32'(timeout), 32'd0);
        check("nto_state",   32'(state),   32'd1);
`endif
        cs = 1'b1;
        tick();
        check("final_state", 32'(state), 32'd0);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
